// File: rtl/sync_addsub_accumulator.sv
// Pipelined signed add/subtract accumulator with sticky overflow and a saturating sample counter.
// Optional macro SATURATE_EN: clamp acc on signed overflow instead of wrapping.
module sync_addsub_accumulator #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 sub,
  input  logic [WIDTH-1:0]     a,
  input  logic                 clear,
  output logic [WIDTH-1:0]     acc,
  output logic                 out_valid,
  output logic                 ovf_now,
  output logic                 ovf_stky,
  output logic [CNT_WIDTH-1:0] count
);

  // Handshake: in_valid qualifies a/sub for exactly the cycle it is high;
  // there is no ready, every valid sample is accepted unless clear is high.
  // out_valid pulses for one cycle after each edge that updated acc.

  logic [WIDTH-1:0] a_r;
  logic             sub_r;
  logic             v1;

  logic [WIDTH-1:0] operand;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [WIDTH-1:0] next_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r   <= '0;
      sub_r <= 1'b0;
      v1    <= 1'b0;
    end else begin
      a_r   <= a;
      sub_r <= sub;
      v1    <= in_valid & ~clear;
    end
  end

  // Sign-extended WIDTH+1 sum; subtract is acc + ~a_r + 1, which is exact
  // even for the most-negative operand, so the top two bits differing
  // is precisely signed overflow.
  always_comb begin
    operand  = sub_r ? ~a_r : a_r;
    sum      = {acc[WIDTH-1], acc} + {operand[WIDTH-1], operand}
               + {{WIDTH{1'b0}}, sub_r};
    ovf      = sum[WIDTH] ^ sum[WIDTH-1];
    next_acc = sum[WIDTH-1:0];
`ifdef SATURATE_EN
    // Overflow direction follows the sign of the old total.
    if (ovf) begin
      next_acc = acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      out_valid <= 1'b0;
      ovf_now   <= 1'b0;
      ovf_stky  <= 1'b0;
      count     <= '0;
    end else if (clear) begin
      acc       <= '0;
      out_valid <= 1'b0;
      ovf_now   <= 1'b0;
      ovf_stky  <= 1'b0;
      count     <= '0;
    end else if (v1) begin
      acc       <= next_acc;
      out_valid <= 1'b1;
      ovf_now   <= ovf;
      ovf_stky  <= ovf_stky | ovf;
      if (count != {CNT_WIDTH{1'b1}}) count <= count + 1'b1;
    end else begin
      out_valid <= 1'b0;
      ovf_now   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_addsub_accumulator.sv
// Directed testbench for sync_addsub_accumulator (WIDTH=8, CNT_WIDTH=4).
// Define SATURATE_EN for both bench and RTL to check the clamping build.
module tb_sync_addsub_accumulator;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       sub;
  logic [7:0] a;
  logic       clear;
  logic [7:0] acc;
  logic       out_valid;
  logic       ovf_now;
  logic       ovf_stky;
  logic [3:0] count;

  int tests = 0;
  int fails = 0;

  sync_addsub_accumulator #(.WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sub(sub), .a(a),
    .clear(clear), .acc(acc), .out_valid(out_valid), .ovf_now(ovf_now),
    .ovf_stky(ovf_stky), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge, clear of the rising edge that samples them.
  task automatic drive(input logic v, input logic s, input logic [7:0] av, input logic c);
    @(negedge clk);
    in_valid = v;
    sub      = s;
    a        = av;
    clear    = c;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; sub = 1'b0; a = 8'h00; clear = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_acc", acc, 8'h00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_ovf_now", ovf_now, 1'b0);
    chk("rst_ovf_stky", ovf_stky, 1'b0);
    chk("rst_count", count, 4'h0);
    reset = 1'b0;

    // Back-to-back 5, 3, -2
    drive(1'b1, 1'b0, 8'd5, 1'b0);
    drive(1'b1, 1'b0, 8'd3, 1'b0);
    drive(1'b1, 1'b0, 8'hFE, 1'b0);
    chk("b2b_acc0", acc, 8'd5);
    chk("b2b_ov0", out_valid, 1'b1);
    idle();
    chk("b2b_acc1", acc, 8'd8);
    chk("b2b_ov1", out_valid, 1'b1);
    idle();
    chk("b2b_acc2", acc, 8'd6);
    chk("b2b_ov2", out_valid, 1'b1);
    chk("b2b_count", count, 4'd3);
    chk("b2b_stky", ovf_stky, 1'b0);
    idle();
    chk("b2b_ov_drop", out_valid, 1'b0);
    chk("b2b_hold", acc, 8'd6);

    // 120 + 10 overflows positive
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b1, 1'b0, 8'd120, 1'b0);
    drive(1'b1, 1'b0, 8'd10, 1'b0);
    idle();
    chk("pos_acc120", acc, 8'd120);
    chk("pos_no_ovf", ovf_now, 1'b0);
    idle();
`ifdef SATURATE_EN
    chk("pos_ovf_acc", acc, 8'h7F);
`else
    chk("pos_ovf_acc", acc, 8'h82);
`endif
    chk("pos_ovf_now", ovf_now, 1'b1);
    chk("pos_ovf_stky", ovf_stky, 1'b1);
    idle();
    chk("pos_now_drop", ovf_now, 1'b0);
    chk("pos_stky_hold", ovf_stky, 1'b1);

    // 0 - (-128) overflows; -1 - (-128) does not
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b1, 1'b1, 8'h80, 1'b0);
    idle();
    chk("clr_stky", ovf_stky, 1'b0);
    idle();
`ifdef SATURATE_EN
    chk("subneg_acc", acc, 8'h7F);
`else
    chk("subneg_acc", acc, 8'h80);
`endif
    chk("subneg_ovf", ovf_now, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b1, 1'b0, 8'hFF, 1'b0);
    drive(1'b1, 1'b1, 8'h80, 1'b0);
    idle();
    chk("m1_acc", acc, 8'hFF);
    idle();
    chk("m1_sub_acc", acc, 8'h7F);
    chk("m1_sub_ovf", ovf_now, 1'b0);
    chk("m1_stky", ovf_stky, 1'b0);
    chk("m1_count", count, 4'd2);

    // 20 adds of 1, counter saturates at 15
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 22; i++) begin
      drive(i < 20, 1'b0, 8'd1, 1'b0);
      if (i >= 2) begin
        chk("ones_acc", acc, (i - 1 > 20) ? 20 : i - 1);
        chk("ones_count", count, (i - 1 > 15) ? 15 : i - 1);
      end
    end
    idle();
    chk("ones_final_acc", acc, 8'd20);
    chk("ones_final_count", count, 4'd15);

    // clear in the same cycle as a valid 9
    drive(1'b1, 1'b0, 8'd9, 1'b1);
    idle();
    chk("clr_acc", acc, 8'd0);
    chk("clr_count", count, 4'd0);
    chk("clr_ovf_stky", ovf_stky, 1'b0);
    chk("clr_out_valid", out_valid, 1'b0);
    idle();
    chk("clr_no9_acc", acc, 8'd0);
    chk("clr_no9_ov", out_valid, 1'b0);

    // sample captured the edge before clear is lost
    drive(1'b1, 1'b0, 8'd7, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    idle();
    chk("lost_acc", acc, 8'd0);
    chk("lost_ov", out_valid, 1'b0);
    chk("lost_count", count, 4'd0);
    idle();
    chk("lost_acc2", acc, 8'd0);

    // async reset mid-stream
    drive(1'b1, 1'b0, 8'd50, 1'b0);
    drive(1'b1, 1'b0, 8'd20, 1'b0);
    drive(1'b1, 1'b0, 8'd30, 1'b0);
    chk("pre_rst_acc", acc, 8'd50);
    #2 reset = 1'b1;
    #1;
    chk("arst_acc", acc, 8'd0);
    chk("arst_ov", out_valid, 1'b0);
    chk("arst_count", count, 4'd0);
    chk("arst_stky", ovf_stky, 1'b0);
    chk("arst_now", ovf_now, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 1'b0, 8'd11, 1'b0);
    idle();
    chk("post_rst_flush", acc, 8'd0);
    chk("post_rst_flush_ov", out_valid, 1'b0);
    idle();
    chk("post_rst_acc", acc, 8'd11);
    chk("post_rst_count", count, 4'd1);
    chk("post_rst_ov", out_valid, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
